// File: rtl/chu_layer_mixer_pkg.sv
// Shared types and constants for the layer mixer core.
package chu_layer_mixer_pkg;

    // Widest key the 32-bit config word can carry (bits [31:2]).
    localparam int unsigned KEY_W = 30;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_OPAQUE = 2'b01,
        MODE_KEY    = 2'b10,
        MODE_BLEND  = 2'b11
    } layer_mode_t;

    // Key is zero-extended from CD bits, so a full-width compare equals a CD-bit compare.
    typedef struct packed {
        layer_mode_t        mode;
        logic [KEY_W-1:0]   key;
    } layer_cfg_t;

    localparam logic [3:0]   GLOBAL_ADDR        = 4'hF;
    localparam int unsigned  CTRL_BYPASS_BIT    = 0;
    localparam int unsigned  CTRL_IMMEDIATE_BIT = 1;

    localparam layer_cfg_t   CFG_RESET = '{mode: MODE_OFF, key: '0};

endpackage

// File: rtl/chu_layer_mix_stage.sv
// One compositing stage: applies layer LAYER to the running pixel and owns that layer's active config.
module chu_layer_mix_stage
    import chu_layer_mixer_pkg::*;
#(
    parameter int unsigned CD    = 12,
    parameter int unsigned NL    = 4,
    parameter int unsigned LAYER = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    input  logic               bypass,
    input  logic               immediate,
    input  layer_cfg_t         pending_cfg,
    input  logic               in_valid,
    input  logic               in_start,
    input  logic [CD-1:0]      in_rgb,
    input  logic [NL*CD-1:0]   in_layers,
    output logic               out_valid,
    output logic               out_start,
    output logic [CD-1:0]      out_rgb,
    output logic [NL*CD-1:0]   out_layers
);

    localparam int unsigned CW = CD / 3;

    logic               valid_q,  valid_d;
    logic               start_q,  start_d;
    logic [CD-1:0]      rgb_q,    rgb_d;
    logic [NL*CD-1:0]   layers_q, layers_d;
    layer_cfg_t         active_cfg_q, active_cfg_d;

    logic               take_pending;
    layer_cfg_t         cfg_use;
    logic [CD-1:0]      lpix;
    logic               key_hit;
    logic [CD-1:0]      mix;

    // A start beat being loaded (or immediate mode) switches this stage to the pending config.
    always_comb begin
        take_pending = immediate | (advance & in_valid & in_start);
        active_cfg_d = take_pending ? pending_cfg : active_cfg_q;
        cfg_use      = take_pending ? pending_cfg : active_cfg_q;
    end

    // Layer operation on the incoming running pixel.
    always_comb begin
        lpix    = in_layers[LAYER*CD +: CD];
        key_hit = (KEY_W'(lpix) == cfg_use.key);
        mix     = in_rgb;
        if (!bypass) begin
            case (cfg_use.mode)
                MODE_OFF:    mix = in_rgb;
                MODE_OPAQUE: mix = lpix;
                MODE_KEY:    mix = key_hit ? in_rgb : lpix;
                MODE_BLEND: begin
                    if (!key_hit) begin
                        for (int unsigned c = 0; c < 3; c++) begin
                            mix[c*CW +: CW] = CW'(((CW+1)'(in_rgb[c*CW +: CW]) +
                                                   (CW+1)'(lpix[c*CW +: CW])) >> 1);
                        end
                    end
                end
                default:     mix = in_rgb;
            endcase
        end
    end

    // Beat payload moves only on advance; bubbles shift like real beats.
    always_comb begin
        valid_d  = valid_q;
        start_d  = start_q;
        rgb_d    = rgb_q;
        layers_d = layers_q;
        if (advance) begin
            valid_d  = in_valid;
            start_d  = in_start;
            rgb_d    = mix;
            layers_d = in_layers;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            start_q      <= 1'b0;
            rgb_q        <= '0;
            layers_q     <= '0;
            active_cfg_q <= CFG_RESET;
        end else begin
            valid_q      <= valid_d;
            start_q      <= start_d;
            rgb_q        <= rgb_d;
            layers_q     <= layers_d;
            active_cfg_q <= active_cfg_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_start  = start_q;
    assign out_rgb    = rgb_q;
    assign out_layers = layers_q;

endmodule

// File: rtl/chu_vga_layer_mixer_core.sv
// N-layer pixel compositor: register decode, pending configs, stall control and the stage chain.
module chu_vga_layer_mixer_core
    import chu_layer_mixer_pkg::*;
#(
    parameter int unsigned CD = 12,
    parameter int unsigned NL = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic               write,
    input  logic [13:0]        addr,
    input  logic [31:0]        wr_data,
    input  logic [CD-1:0]      si_rgb,
    input  logic [NL*CD-1:0]   si_layer_rgb,
    input  logic               si_start,
    input  logic               si_valid,
    output logic               si_ready,
    output logic [CD-1:0]      so_rgb,
    output logic               so_start,
    output logic               so_valid,
    input  logic               so_ready
);

    layer_cfg_t         pending_cfg_q [NL];
    layer_cfg_t         pending_cfg_d [NL];
    logic               bypass_q,    bypass_d;
    logic               immediate_q, immediate_d;

    logic               wr_en;
    logic               advance;
    logic               valid_s  [NL+1];
    logic               start_s  [NL+1];
    logic [CD-1:0]      rgb_s    [NL+1];
    logic [NL*CD-1:0]   layers_s [NL+1];
    logic               unused_bits;

    // Register decode; unmapped addresses are ignored.
    always_comb begin
        wr_en         = cs & write;
        pending_cfg_d = pending_cfg_q;
        bypass_d      = bypass_q;
        immediate_d   = immediate_q;
        for (int k = 0; k < NL; k++) begin
            if (wr_en && addr[3:0] == 4'(k)) begin
                pending_cfg_d[k].mode = layer_mode_t'(wr_data[1:0]);
                pending_cfg_d[k].key  = KEY_W'(wr_data[CD+1:2]);
            end
        end
        if (wr_en && addr[3:0] == GLOBAL_ADDR) begin
            bypass_d    = wr_data[CTRL_BYPASS_BIT];
            immediate_d = wr_data[CTRL_IMMEDIATE_BIT];
        end
    end

    // Configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NL; k++) begin
                pending_cfg_q[k] <= CFG_RESET;
            end
            bypass_q    <= 1'b0;
            immediate_q <= 1'b0;
        end else begin
            pending_cfg_q <= pending_cfg_d;
            bypass_q      <= bypass_d;
            immediate_q   <= immediate_d;
        end
    end

    // Uniform stall: every stage advances when the output slot is free or being drained.
    assign advance  = ~valid_s[NL] | so_ready;
    assign si_ready = advance;

    assign valid_s[0]  = si_valid;
    assign start_s[0]  = si_start;
    assign rgb_s[0]    = si_rgb;
    assign layers_s[0] = si_layer_rgb;

    for (genvar k = 0; k < NL; k++) begin : g_stage
        chu_layer_mix_stage #(
            .CD    (CD),
            .NL    (NL),
            .LAYER (k)
        ) u_stage (
            .clk         (clk),
            .reset       (reset),
            .advance     (advance),
            .bypass      (bypass_q),
            .immediate   (immediate_q),
            .pending_cfg (pending_cfg_q[k]),
            .in_valid    (valid_s[k]),
            .in_start    (start_s[k]),
            .in_rgb      (rgb_s[k]),
            .in_layers   (layers_s[k]),
            .out_valid   (valid_s[k+1]),
            .out_start   (start_s[k+1]),
            .out_rgb     (rgb_s[k+1]),
            .out_layers  (layers_s[k+1])
        );
    end

    assign so_valid = valid_s[NL];
    assign so_start = start_s[NL];
    assign so_rgb   = rgb_s[NL];

    // Address/data bits outside the decoded map and the spent layer vector.
    assign unused_bits = &{1'b0, addr[13:4], wr_data[31:CD+2], layers_s[NL]};

endmodule

// File: tb/tb_chu_vga_layer_mixer_core.sv
// Scoreboard bench for the layer mixer: randomized frames against a per-frame config reference model.
module tb_chu_vga_layer_mixer_core;

    localparam int unsigned CD = 12;
    localparam int unsigned NL = 4;
    localparam int unsigned CW = CD / 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cs = 1'b0;
    logic              write = 1'b0;
    logic [13:0]       addr = '0;
    logic [31:0]       wr_data = '0;
    logic [CD-1:0]     si_rgb = '0;
    logic [NL*CD-1:0]  si_layer_rgb = '0;
    logic              si_start = 1'b0;
    logic              si_valid = 1'b0;
    logic              si_ready;
    logic [CD-1:0]     so_rgb;
    logic              so_start;
    logic              so_valid;
    logic              so_ready = 1'b1;

    chu_vga_layer_mixer_core #(.CD(CD), .NL(NL)) dut (
        .clk          (clk),
        .reset        (reset),
        .cs           (cs),
        .write        (write),
        .addr         (addr),
        .wr_data      (wr_data),
        .si_rgb       (si_rgb),
        .si_layer_rgb (si_layer_rgb),
        .si_start     (si_start),
        .si_valid     (si_valid),
        .si_ready     (si_ready),
        .so_rgb       (so_rgb),
        .so_start     (so_start),
        .so_valid     (so_valid),
        .so_ready     (so_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CD-1:0] rgb;
        logic          start;
        int            acc;
        bit            chk_lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    // Register shadow (what has been written) and the config the current frame was started with.
    int            sh_mode [NL];
    logic [CD-1:0] sh_key  [NL];
    int            sn_mode [NL];
    logic [CD-1:0] sn_key  [NL];
    bit            bp_shadow = 1'b0;
    int            frame_beats = NL;

    bit            prev_stall = 1'b0;
    logic [CD-1:0] prev_rgb;
    logic          prev_start;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       so_ready = 1'b1;
            1:       so_ready = ($urandom_range(0, 3) != 0);
            default: so_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: each enabled layer, bottom to top, over the background.
    function automatic logic [CD-1:0] ref_pix(input logic [CD-1:0] bg, input logic [NL*CD-1:0] lay);
        logic [CD-1:0] p, l, q;
        int a, b;
        p = bg;
        if (bp_shadow) return bg;
        for (int k = 0; k < NL; k++) begin
            l = lay[k*CD +: CD];
            case (sn_mode[k])
                1: p = l;
                2: if (l != sn_key[k]) p = l;
                3: if (l != sn_key[k]) begin
                       q = '0;
                       for (int c = 0; c < 3; c++) begin
                           a = int'(p[c*CW +: CW]);
                           b = int'(l[c*CW +: CW]);
                           q[c*CW +: CW] = CW'((a + b) / 2);
                       end
                       p = q;
                   end
                default: ;
            endcase
        end
        return p;
    endfunction

    function automatic logic [NL*CD-1:0] mk_lay(input logic [CD-1:0] l0, input logic [CD-1:0] l1,
                                                input logic [CD-1:0] l2, input logic [CD-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [CD-1:0] rand_pix();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return {CD{1'b1}};
            2:       return CD'(12'h0F0);
            default: return CD'($urandom);
        endcase
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NL; k++) begin
            sh_mode[k] = 0; sh_key[k] = '0;
            sn_mode[k] = 0; sn_key[k] = '0;
        end
        bp_shadow   = 1'b0;
        frame_beats = NL;
    endtask

    // Entered at posedge+1; leaves at posedge+1.
    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = 14'(a); wr_data = d;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
        if (32'(a) < NL) begin
            sh_mode[a] = int'(d[1:0]);
            sh_key[a]  = d[CD+1:2];
        end else if (a == 4'hF) begin
            bp_shadow = d[0];
        end
    endtask

    task automatic send_beat(input bit st, input logic [CD-1:0] bg, input logic [NL*CD-1:0] lay,
                             input bit use_exp, input logic [CD-1:0] exp_rgb, input bit chk_lat);
        exp_t e;
        int   n = 0;
        bit   ok = 1'b0;
        si_valid = 1'b1; si_start = st; si_rgb = bg; si_layer_rgb = lay;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (si_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got no si_ready expected accept within 200 cycles");
        end else begin
            if (st) begin
                for (int k = 0; k < NL; k++) begin
                    sn_mode[k] = sh_mode[k];
                    sn_key[k]  = sh_key[k];
                end
                frame_beats = 0;
            end
            frame_beats++;
            e.rgb     = use_exp ? exp_rgb : ref_pix(bg, lay);
            e.start   = st;
            e.acc     = cyc;
            e.chk_lat = chk_lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        si_valid = 1'b0; si_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            chk("si_ready", 32'(si_ready), 32'(!so_valid || so_ready));
            if (prev_stall) begin
                chk("stall_valid", 32'(so_valid), 32'd1);
                chk("stall_rgb", 32'(so_rgb), 32'(prev_rgb));
                chk("stall_start", 32'(so_start), 32'(prev_start));
            end
            prev_stall = 1'b0;
            if (so_valid === 1'b1 && so_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_beat: got rgb %h expected no beat", so_rgb);
                end else begin
                    e = sb.pop_front();
                    chk("so_rgb", 32'(so_rgb), 32'(e.rgb));
                    chk("so_start", 32'(so_start), 32'(e.start));
                    if (e.chk_lat) chk("latency", 32'(cyc - e.acc), 32'(NL));
                end
            end else if (so_valid === 1'b1) begin
                prev_stall = 1'b1;
                prev_rgb   = so_rgb;
                prev_start = so_start;
            end
        end
    end

    initial begin
        logic [CD-1:0]    bg;
        logic [NL*CD-1:0] lay;
        logic [3:0]       wa;
        clear_model();

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_so_valid", 32'(so_valid), 32'd0);
        chk("rst_so_rgb", 32'(so_rgb), 32'd0);
        chk("rst_so_start", 32'(so_start), 32'd0);
        chk("rst_si_ready", 32'(si_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // All layers off: background passes through with latency NL.
        for (int i = 0; i < 4; i++)
            send_beat(i == 0, CD'(12'h008), mk_lay(12'h123, 12'h456, 12'h789, 12'hABC), 1, CD'(12'h008), 1);

        // Layer 2 key mode, key 000.
        wr_reg(4'd2, 32'h0000_0002);
        send_beat(1, CD'(12'h123), mk_lay(12'h0, 12'h0, 12'h000, 12'h0), 1, CD'(12'h123), 1);
        send_beat(0, CD'(12'h123), mk_lay(12'h0, 12'h0, 12'hF00, 12'h0), 1, CD'(12'hF00), 1);
        send_beat(0, CD'(12'h456), mk_lay(12'h0, 12'h0, 12'h000, 12'h0), 1, CD'(12'h456), 1);
        send_beat(0, CD'(12'h456), mk_lay(12'h0, 12'h0, 12'h000, 12'h0), 1, CD'(12'h456), 1);

        // Layer 0 blend with key FFF, layer 2 off.
        wr_reg(4'd2, 32'h0000_0000);
        wr_reg(4'd0, 32'h0000_3FFF);
        send_beat(1, CD'(12'h0F0), mk_lay(12'h00F, 12'h0, 12'h0, 12'h0), 1, CD'(12'h077), 0);
        send_beat(0, CD'(12'h0F0), mk_lay(12'hFFF, 12'h0, 12'h0, 12'h0), 1, CD'(12'h0F0), 0);
        send_beat(0, CD'(12'h8A4), mk_lay(12'h462, 12'h0, 12'h0, 12'h0), 1, CD'(12'h683), 0);
        send_beat(0, CD'(12'hFFF), mk_lay(12'h001, 12'h0, 12'h0, 12'h0), 1, CD'(12'h778), 0);

        // Mid-frame writes take effect only from the next start beat.
        wr_reg(4'd0, 32'h0000_0000);
        wr_reg(4'd3, 32'h0000_0001);
        send_beat(0, CD'(12'h111), mk_lay(12'hFFF, 12'h0, 12'h0, 12'hABC), 1, CD'(12'h111), 0);
        send_beat(0, CD'(12'h111), mk_lay(12'hFFF, 12'h0, 12'h0, 12'hABC), 1, CD'(12'h111), 0);
        send_beat(1, CD'(12'h222), mk_lay(12'hFFF, 12'h0, 12'h0, 12'hABC), 1, CD'(12'hABC), 0);
        for (int i = 0; i < 3; i++)
            send_beat(0, CD'(12'h222), mk_lay(12'h0, 12'h0, 12'h0, 12'hABC), 1, CD'(12'hABC), 0);
        drain();

        // Fill the pipeline with so_ready low and hold it for 5 cycles.
        rdy_mode = 2;
        idle(1);
        for (int i = 0; i < NL; i++)
            send_beat(0, CD'($urandom), mk_lay(rand_pix(), rand_pix(), rand_pix(), rand_pix()), 0, '0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_si_ready", 32'(si_ready), 32'd0);
        end
        @(posedge clk); #1;
        drain();

        // Randomized frames, layer configs and back-pressure.
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if (frame_beats >= NL && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 7) == 0) wa = 4'($urandom_range(NL, 14));
                else                           wa = 4'($urandom_range(0, NL-1));
                wr_reg(wa, (32'(rand_pix()) << 2) | 32'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            bg  = CD'($urandom);
            lay = mk_lay(rand_pix(), rand_pix(), rand_pix(), rand_pix());
            send_beat($urandom_range(0, 11) == 0, bg, lay, 0, '0, 0);
        end
        drain();

        // Bypass: background only, regardless of layer configs.
        wr_reg(4'hF, 32'h0000_0001);
        rdy_mode = 1;
        for (int i = 0; i < 12; i++) begin
            bg = CD'($urandom);
            send_beat(i == 0, bg, mk_lay(rand_pix(), rand_pix(), rand_pix(), rand_pix()), 1, bg, 0);
        end
        drain();
        wr_reg(4'hF, 32'h0000_0000);

        // Reset with beats in flight and a non-OFF config active.
        wr_reg(4'd1, 32'h0000_0001);
        rdy_mode = 2;
        idle(1);
        send_beat(1, CD'(12'h321), mk_lay(12'h0, 12'h999, 12'h0, 12'h0), 0, '0, 0);
        send_beat(0, CD'(12'h321), mk_lay(12'h0, 12'h999, 12'h0, 12'h0), 0, '0, 0);
        send_beat(0, CD'(12'h321), mk_lay(12'h0, 12'h999, 12'h0, 12'h0), 0, '0, 0);
        reset = 1'b1;
        sb.delete();
        clear_model();
        @(posedge clk); #1;
        reset = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        chk("post_rst_so_valid", 32'(so_valid), 32'd0);
        chk("post_rst_so_rgb", 32'(so_rgb), 32'd0);
        chk("post_rst_so_start", 32'(so_start), 32'd0);
        @(posedge clk); #1;
        send_beat(1, CD'(12'h5A5), mk_lay(12'h0, 12'hABC, 12'h0, 12'h0), 1, CD'(12'h5A5), 1);
        send_beat(0, CD'(12'h5A6), mk_lay(12'h0, 12'hABC, 12'h0, 12'h0), 1, CD'(12'h5A6), 1);
        drain();
        idle(NL + 2);
        chk("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
